// File: rtl/iagu_add_mc_if.sv
// Read-address channel between the ADD-layer address generator and the IO buffer.
// The generator drives address/source/valid/last; the buffer answers with ready.
interface iagu_add_mc_if #(
    parameter int ADDR_W = 13,
    parameter int SRC_W  = 2
);
    logic [ADDR_W-1:0] o_d_addr;
    logic [SRC_W-1:0]  o_src;
    logic              o_rd_en;
    logic              o_last;
    logic              i_rd_ready;

    modport master (
        output o_d_addr,
        output o_src,
        output o_rd_en,
        output o_last,
        input  i_rd_ready
    );

    modport slave (
        input  o_d_addr,
        input  o_src,
        input  o_rd_en,
        input  o_last,
        output i_rd_ready
    );
endinterface

// File: rtl/iagu_add_mc.sv
// Multi-source input address generator for the element-wise ADD layer.
// Walks src -> x -> y -> piece and issues one registered read address per accepted handshake.
module iagu_add_mc #(
    parameter int ADDR_W  = 13,
    parameter int DIM_W   = 8,
    parameter int NUM_SRC = 2,
    parameter int SRC_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_calculate,
    input  logic [NUM_SRC*ADDR_W-1:0] i_base,
    input  logic [DIM_W-1:0]          out_x_length,
    input  logic [DIM_W-1:0]          out_y_length,
    input  logic [DIM_W-1:0]          in_piece,
    input  logic [DIM_W-1:0]          i_row_pitch,
    iagu_add_mc_if.master             rd,
    output logic                      o_feature_end,
    output logic                      o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [NUM_SRC*ADDR_W-1:0] base_q;
    logic [DIM_W-1:0]          x_len_q;
    logic [DIM_W-1:0]          y_len_q;
    logic [DIM_W-1:0]          p_len_q;
    logic [DIM_W-1:0]          pitch_q;
    logic [SRC_W-1:0]          src_cnt;
    logic [DIM_W-1:0]          x_cnt;
    logic [DIM_W-1:0]          y_cnt;
    logic [DIM_W-1:0]          p_cnt;
    logic [ADDR_W-1:0]         row_off;

    logic                      src_wrap;
    logic                      x_wrap;
    logic                      y_wrap;
    logic                      row_step;
    logic [SRC_W-1:0]          nxt_src;
    logic [DIM_W-1:0]          nxt_x;
    logic [DIM_W-1:0]          nxt_y;
    logic [DIM_W-1:0]          nxt_p;
    logic [ADDR_W-1:0]         nxt_row_off;
    logic [ADDR_W-1:0]         base_sel;
    logic [ADDR_W-1:0]         nxt_addr;
    logic                      nxt_last;
    logic                      any_zero;
    logic                      first_last;
    logic                      handshake;

    // Next counter position and its address, computed ahead so the outputs can be registered.
    always_comb begin
        src_wrap    = (src_cnt == SRC_W'(NUM_SRC - 1));
        x_wrap      = (x_cnt == x_len_q - 1'b1);
        y_wrap      = (y_cnt == y_len_q - 1'b1);
        row_step    = src_wrap & x_wrap;
        nxt_src     = src_wrap ? '0 : src_cnt + 1'b1;
        nxt_x       = src_wrap ? (x_wrap ? '0 : x_cnt + 1'b1) : x_cnt;
        nxt_y       = row_step ? (y_wrap ? '0 : y_cnt + 1'b1) : y_cnt;
        nxt_p       = (row_step & y_wrap) ? p_cnt + 1'b1 : p_cnt;
        nxt_row_off = row_step ? row_off + ADDR_W'(pitch_q) : row_off;
        base_sel    = base_q[0 +: ADDR_W];
        for (int s = 1; s < NUM_SRC; s++) begin
            if (nxt_src == SRC_W'(s)) begin
                base_sel = base_q[s*ADDR_W +: ADDR_W];
            end
        end
        nxt_addr    = base_sel + nxt_row_off + ADDR_W'(nxt_x);
        nxt_last    = (nxt_src == SRC_W'(NUM_SRC - 1)) && (nxt_x == x_len_q - 1'b1) &&
                      (nxt_y == y_len_q - 1'b1) && (nxt_p == p_len_q - 1'b1);
        any_zero    = (out_x_length == '0) || (out_y_length == '0) || (in_piece == '0);
        first_last  = (NUM_SRC == 1) && (out_x_length == DIM_W'(1)) &&
                      (out_y_length == DIM_W'(1)) && (in_piece == DIM_W'(1));
        handshake   = rd.o_rd_en & rd.i_rd_ready;
    end

    // Job FSM; every output is a register so nothing combinationally follows i_rd_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            base_q        <= '0;
            x_len_q       <= '0;
            y_len_q       <= '0;
            p_len_q       <= '0;
            pitch_q       <= '0;
            src_cnt       <= '0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            p_cnt         <= '0;
            row_off       <= '0;
            rd.o_d_addr   <= '0;
            rd.o_src      <= '0;
            rd.o_rd_en    <= 1'b0;
            rd.o_last     <= 1'b0;
            o_feature_end <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_feature_end <= 1'b0;
                    if (start_calculate) begin
                        base_q  <= i_base;
                        x_len_q <= out_x_length;
                        y_len_q <= out_y_length;
                        p_len_q <= in_piece;
                        pitch_q <= (i_row_pitch == '0) ? out_x_length : i_row_pitch;
                        src_cnt <= '0;
                        x_cnt   <= '0;
                        y_cnt   <= '0;
                        p_cnt   <= '0;
                        row_off <= '0;
                        o_busy  <= 1'b1;
                        if (any_zero) begin
                            state         <= DONE;
                            o_feature_end <= 1'b1;
                        end else begin
                            state       <= RUN;
                            rd.o_d_addr <= i_base[0 +: ADDR_W];
                            rd.o_src    <= '0;
                            rd.o_rd_en  <= 1'b1;
                            rd.o_last   <= first_last;
                        end
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (rd.o_last) begin
                            state         <= DONE;
                            rd.o_rd_en    <= 1'b0;
                            rd.o_last     <= 1'b0;
                            o_feature_end <= 1'b1;
                        end else begin
                            src_cnt     <= nxt_src;
                            x_cnt       <= nxt_x;
                            y_cnt       <= nxt_y;
                            p_cnt       <= nxt_p;
                            row_off     <= nxt_row_off;
                            rd.o_d_addr <= nxt_addr;
                            rd.o_src    <= nxt_src;
                            rd.o_last   <= nxt_last;
                        end
                    end
                end
                DONE: begin
                    o_feature_end <= 1'b0;
                    o_busy        <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iagu_add_mc.sv
// Self-checking bench for iagu_add_mc: a 2-source and a 1-source instance checked
// against an address list built directly from the volume/pitch arithmetic.
module tb_iagu_add_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start2;
    logic        start1;
    logic [25:0] base2;
    logic [12:0] base1;
    logic [7:0]  x_len;
    logic [7:0]  y_len;
    logic [7:0]  p_len;
    logic [7:0]  pitch;
    logic        ready;
    logic        fe2;
    logic        busy2;
    logic        fe1;
    logic        busy1;
    int          sel;

    int          errors = 0;
    int          checks = 0;

    int          exp_addr[$];
    int          exp_src[$];
    int          exp_last[$];

    logic [31:0] obs_addr;
    logic [31:0] obs_src;
    logic        obs_rd_en;
    logic        obs_last;
    logic        obs_fe;
    logic        obs_busy;

    iagu_add_mc_if #(.ADDR_W(13), .SRC_W(2)) rd2();
    iagu_add_mc_if #(.ADDR_W(13), .SRC_W(1)) rd1();

    assign rd2.i_rd_ready = ready;
    assign rd1.i_rd_ready = ready;

    iagu_add_mc #(.ADDR_W(13), .DIM_W(8), .NUM_SRC(2), .SRC_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start_calculate(start2), .i_base(base2),
        .out_x_length(x_len), .out_y_length(y_len), .in_piece(p_len), .i_row_pitch(pitch),
        .rd(rd2), .o_feature_end(fe2), .o_busy(busy2)
    );

    iagu_add_mc #(.ADDR_W(13), .DIM_W(8), .NUM_SRC(1), .SRC_W(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_calculate(start1), .i_base(base1),
        .out_x_length(x_len), .out_y_length(y_len), .in_piece(p_len), .i_row_pitch(pitch),
        .rd(rd1), .o_feature_end(fe1), .o_busy(busy1)
    );

    always #5 clk = ~clk;

    always_comb begin
        obs_addr  = (sel == 1) ? 32'(rd1.o_d_addr) : 32'(rd2.o_d_addr);
        obs_src   = (sel == 1) ? 32'(rd1.o_src)    : 32'(rd2.o_src);
        obs_rd_en = (sel == 1) ? rd1.o_rd_en : rd2.o_rd_en;
        obs_last  = (sel == 1) ? rd1.o_last  : rd2.o_last;
        obs_fe    = (sel == 1) ? fe1   : fe2;
        obs_busy  = (sel == 1) ? busy1 : busy2;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic pick_ready(input int rmode, input int cyc);
        if (rmode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
        if (rmode == 2) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    task automatic scramble_config();
        base2 = 26'($urandom);
        base1 = 13'($urandom);
        x_len = 8'($urandom);
        y_len = 8'($urandom);
        p_len = 8'($urandom);
        pitch = 8'($urandom);
    endtask

    // One job: build the expected address list, start, then follow handshakes cycle by cycle.
    task automatic applyStimulus(input int s, input int rmode, input int b0, input int b1,
                                 input int x, input int y, input int p, input int pt,
                                 input int abort_at, input int stray_at);
        int nsrc;
        int eff;
        int bases[2];
        int cyc;
        int popped;
        bit zero_job;
        nsrc     = (s == 1) ? 1 : 2;
        eff      = (pt == 0) ? x : pt;
        bases[0] = b0;
        bases[1] = b1;
        zero_job = (x == 0) || (y == 0) || (p == 0);
        exp_addr.delete();
        exp_src.delete();
        exp_last.delete();
        if (!zero_job) begin
            for (int pi = 0; pi < p; pi++)
                for (int yi = 0; yi < y; yi++)
                    for (int xi = 0; xi < x; xi++)
                        for (int si = 0; si < nsrc; si++) begin
                            exp_addr.push_back((bases[si] + (pi * y + yi) * eff + xi) & 32'h1FFF);
                            exp_src.push_back(si);
                            exp_last.push_back(((pi == p-1) && (yi == y-1) && (xi == x-1) && (si == nsrc-1)) ? 1 : 0);
                        end
        end
        sel = s;
        @(negedge clk);
        base2 = {13'(b1), 13'(b0)};
        base1 = 13'(b0);
        x_len = 8'(x);
        y_len = 8'(y);
        p_len = 8'(p);
        pitch = 8'(pt);
        if (s == 1) start1 = 1'b1; else start2 = 1'b1;
        ready = pick_ready(rmode, 0);
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        scramble_config();
        if (zero_job) begin
            checkOutput("zero_rd_en", 32'(obs_rd_en), 32'd0);
            checkOutput("zero_fe", 32'(obs_fe), 32'd1);
            checkOutput("zero_busy", 32'(obs_busy), 32'd1);
            @(negedge clk);
            checkOutput("zero_fe_after", 32'(obs_fe), 32'd0);
            checkOutput("zero_busy_after", 32'(obs_busy), 32'd0);
            return;
        end
        cyc    = 0;
        popped = 0;
        while (exp_addr.size() > 0) begin
            start1 = 1'b0;
            start2 = 1'b0;
            if (abort_at >= 0 && popped == abort_at) begin
                rst = 1'b0;
                #1;
                checkOutput("abort_addr", obs_addr, 32'd0);
                checkOutput("abort_src", obs_src, 32'd0);
                checkOutput("abort_rd_en", 32'(obs_rd_en), 32'd0);
                checkOutput("abort_last", 32'(obs_last), 32'd0);
                checkOutput("abort_fe", 32'(obs_fe), 32'd0);
                checkOutput("abort_busy", 32'(obs_busy), 32'd0);
                @(negedge clk);
                rst   = 1'b1;
                ready = 1'b1;
                @(negedge clk);
                checkOutput("abort_no_fe", 32'(obs_fe), 32'd0);
                checkOutput("abort_idle_rd_en", 32'(obs_rd_en), 32'd0);
                return;
            end
            if (cyc == stray_at) begin
                if (s == 1) start1 = 1'b1; else start2 = 1'b1;
            end
            ready = pick_ready(rmode, cyc);
            checkOutput("run_rd_en", 32'(obs_rd_en), 32'd1);
            checkOutput("run_busy", 32'(obs_busy), 32'd1);
            checkOutput("run_fe", 32'(obs_fe), 32'd0);
            checkOutput("addr", obs_addr, 32'(exp_addr[0]));
            checkOutput("src", obs_src, 32'(exp_src[0]));
            checkOutput("last", 32'(obs_last), 32'(exp_last[0]));
            if (ready) begin
                void'(exp_addr.pop_front());
                void'(exp_src.pop_front());
                void'(exp_last.pop_front());
                popped++;
            end
            cyc++;
            if (cyc > 4000) begin
                checks++;
                errors++;
                $error("FAIL timeout observed=%0d expected=%0d", exp_addr.size(), 0);
                return;
            end
            @(negedge clk);
        end
        start1 = 1'b0;
        start2 = 1'b0;
        checkOutput("end_rd_en", 32'(obs_rd_en), 32'd0);
        checkOutput("end_fe", 32'(obs_fe), 32'd1);
        checkOutput("end_busy", 32'(obs_busy), 32'd1);
        @(negedge clk);
        checkOutput("end_fe_after", 32'(obs_fe), 32'd0);
        checkOutput("end_busy_after", 32'(obs_busy), 32'd0);
    endtask

    initial begin
        rst    = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        ready  = 1'b0;
        sel    = 0;
        scramble_config();
        repeat (3) @(negedge clk);
        checkOutput("reset_addr2", 32'(rd2.o_d_addr), 32'd0);
        checkOutput("reset_ctrl2", 32'({rd2.o_src, rd2.o_rd_en, rd2.o_last, fe2, busy2}), 32'd0);
        checkOutput("reset_addr1", 32'(rd1.o_d_addr), 32'd0);
        checkOutput("reset_ctrl1", 32'({rd1.o_src, rd1.o_rd_en, rd1.o_last, fe1, busy1}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] dense 2-source");
        applyStimulus(0, 0, 'h000, 'h100, 2, 2, 2, 0, -1, -1);
        $display("[TB] padded pitch");
        applyStimulus(1, 0, 'h010, 0, 2, 2, 2, 4, -1, -1);
        $display("[TB] backpressure");
        applyStimulus(0, 1, 'h000, 'h100, 2, 2, 2, 0, -1, -1);
        $display("[TB] address wrap");
        applyStimulus(1, 0, 'h1FFE, 0, 4, 1, 1, 0, -1, -1);
        $display("[TB] zero length");
        applyStimulus(0, 0, 'h000, 'h100, 0, 2, 2, 0, -1, -1);
        applyStimulus(1, 0, 'h020, 0, 3, 0, 1, 0, -1, -1);
        $display("[TB] stray start during run");
        applyStimulus(0, 0, 'h000, 'h100, 2, 2, 2, 0, -1, 3);
        $display("[TB] single element");
        applyStimulus(1, 0, 'h0AA, 0, 1, 1, 1, 0, -1, -1);
        $display("[TB] reset mid-job");
        applyStimulus(0, 0, 'h000, 'h100, 2, 2, 2, 0, 5, -1);
        applyStimulus(0, 0, 'h000, 'h100, 2, 2, 2, 0, -1, -1);

        $display("[TB] randomized jobs");
        for (int i = 0; i < 12; i++) begin
            int rx;
            int rp;
            rx = $urandom_range(1, 4);
            rp = ($urandom_range(0, 1) == 0) ? 0 : rx + $urandom_range(0, 5);
            applyStimulus(i % 2, 2, $urandom_range(0, 8191), $urandom_range(0, 8191),
                          rx, $urandom_range(1, 3), $urandom_range(1, 3), rp, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
